// File: rtl/psum_bank_array.sv
// Banked partial-sum store with a saturating accumulate pipeline (S0 read, S1 add/commit)
// and a controller drain port that shares each bank's read port with reductions.
module psum_bank_array #(
  parameter int unsigned SMALL_BANK_COUNT = 3,
  parameter int unsigned BIG_BANK_COUNT   = 3,
  parameter int unsigned BANK_INDEX_WIDTH = 3,
  parameter int unsigned SMALL_DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH       = 8,
  parameter int unsigned DATA_WIDTH       = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [BANK_INDEX_WIDTH-1:0] wr_bank,
  input  logic [ADDR_WIDTH-1:0]       wr_addr,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic                        rd_valid,
  input  logic [BANK_INDEX_WIDTH-1:0] rd_bank,
  input  logic [ADDR_WIDTH-1:0]       rd_addr,
  input  logic                        drain_req,
  input  logic [BANK_INDEX_WIDTH-1:0] drain_bank,
  input  logic [ADDR_WIDTH-1:0]       drain_addr,
  output logic                        drain_stall,
  output logic                        drain_valid,
  output logic [DATA_WIDTH-1:0]       drain_data,
  output logic                        sat,
  output logic                        err_oob
);

  localparam int unsigned TOTAL_BANKS  = SMALL_BANK_COUNT + BIG_BANK_COUNT;
  localparam int unsigned BIG_DEPTH    = 1 << ADDR_WIDTH;
  localparam int unsigned SMALL_SEL_W  = (SMALL_BANK_COUNT > 1) ? $clog2(SMALL_BANK_COUNT) : 1;
  localparam int unsigned BIG_SEL_W    = (BIG_BANK_COUNT > 1) ? $clog2(BIG_BANK_COUNT) : 1;
  localparam int unsigned SMALL_ADDR_W = (SMALL_DEPTH > 1) ? $clog2(SMALL_DEPTH) : 1;

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Bank storage is intentionally not reset.
  logic [DATA_WIDTH-1:0] small_mem [SMALL_BANK_COUNT][SMALL_DEPTH];
  logic [DATA_WIDTH-1:0] big_mem   [BIG_BANK_COUNT][BIG_DEPTH];

  // S1 pipeline registers
  logic                        s1_valid;
  logic                        rd_valid_q;
  logic                        wr_oob_q;
  logic [BANK_INDEX_WIDTH-1:0] wr_bank_q;
  logic [ADDR_WIDTH-1:0]       wr_addr_q;
  logic [DATA_WIDTH-1:0]       wr_data_q;
  logic [DATA_WIDTH-1:0]       rd_q;

  logic [DATA_WIDTH:0]         sum_wide_c;
  logic [DATA_WIDTH-1:0]       addend_c;
  logic [DATA_WIDTH-1:0]       sum_c;
  logic                        ovf_c;
  logic                        commit_c;
  logic                        wr_oob_c;
  logic                        rd_oob_c;
  logic                        drain_oob_c;
  logic                        drain_accept_c;
  logic [DATA_WIDTH-1:0]       rd_word_c;
  logic [DATA_WIDTH-1:0]       drain_word_c;

  function automatic logic is_oob(input logic [BANK_INDEX_WIDTH-1:0] bank,
                                  input logic [ADDR_WIDTH-1:0]       addr);
    return (32'(bank) >= TOTAL_BANKS) ||
           ((32'(bank) < SMALL_BANK_COUNT) && (32'(addr) >= SMALL_DEPTH));
  endfunction

  function automatic logic [DATA_WIDTH-1:0] mem_read(input logic [BANK_INDEX_WIDTH-1:0] bank,
                                                     input logic [ADDR_WIDTH-1:0]       addr);
    logic [DATA_WIDTH-1:0] word;
    word = '0;
    if (32'(bank) < SMALL_BANK_COUNT)
      word = small_mem[SMALL_SEL_W'(bank)][SMALL_ADDR_W'(addr)];
    else if (32'(bank) < TOTAL_BANKS)
      word = big_mem[BIG_SEL_W'(32'(bank) - SMALL_BANK_COUNT)][addr];
    return word;
  endfunction

  // S1: signed saturating accumulate of the array result with the fetched psum
  always_comb begin
    addend_c   = rd_valid_q ? rd_q : '0;
    sum_wide_c = {wr_data_q[DATA_WIDTH-1], wr_data_q} + {addend_c[DATA_WIDTH-1], addend_c};
    ovf_c      = sum_wide_c[DATA_WIDTH] ^ sum_wide_c[DATA_WIDTH-1];
    sum_c      = sum_wide_c[DATA_WIDTH-1:0];
    if (ovf_c)
      sum_c = sum_wide_c[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    commit_c   = s1_valid & ~wr_oob_q;
  end

  // Read ports: a same-cycle S1 commit to the address being read is forwarded
  always_comb begin
    wr_oob_c       = is_oob(wr_bank, wr_addr);
    rd_oob_c       = is_oob(rd_bank, rd_addr);
    drain_oob_c    = is_oob(drain_bank, drain_addr);
    drain_accept_c = drain_req & ~drain_stall;

    rd_word_c = '0;
    if (!rd_oob_c) begin
      if (commit_c && (wr_bank_q == rd_bank) && (wr_addr_q == rd_addr))
        rd_word_c = sum_c;
      else
        rd_word_c = mem_read(rd_bank, rd_addr);
    end

    drain_word_c = '0;
    if (!drain_oob_c) begin
      if (commit_c && (wr_bank_q == drain_bank) && (wr_addr_q == drain_addr))
        drain_word_c = sum_c;
      else
        drain_word_c = mem_read(drain_bank, drain_addr);
    end
  end

  // A reduction read owns the shared bank read port
  assign drain_stall = drain_req & wr_en & rd_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      rd_valid_q  <= 1'b0;
      wr_oob_q    <= 1'b0;
      wr_bank_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_q        <= '0;
      drain_valid <= 1'b0;
      drain_data  <= '0;
      sat         <= 1'b0;
      err_oob     <= 1'b0;
    end else begin
      s1_valid <= wr_en;
      if (wr_en) begin
        wr_bank_q  <= wr_bank;
        wr_addr_q  <= wr_addr;
        wr_data_q  <= wr_data;
        wr_oob_q   <= wr_oob_c;
        rd_valid_q <= rd_valid;
        rd_q       <= rd_valid ? rd_word_c : '0;
      end
      drain_valid <= drain_accept_c;
      if (drain_accept_c)
        drain_data <= drain_word_c;
      sat     <= commit_c & ovf_c;
      err_oob <= (wr_en & (wr_oob_c | (rd_valid & rd_oob_c))) | (drain_accept_c & drain_oob_c);
    end
  end

  // Commit the S1 sum; OOB writes never reach storage
  always_ff @(posedge clk) begin
    if (commit_c) begin
      if (32'(wr_bank_q) < SMALL_BANK_COUNT)
        small_mem[SMALL_SEL_W'(wr_bank_q)][SMALL_ADDR_W'(wr_addr_q)] <= sum_c;
      else
        big_mem[BIG_SEL_W'(32'(wr_bank_q) - SMALL_BANK_COUNT)][wr_addr_q] <= sum_c;
    end
  end

endmodule
